// File: rtl/rot_sq_pkg.sv
// rtl/rot_sq_pkg.sv - shared constants, state encoding and pattern decode for rot_square_ctrl
package rot_sq_pkg;

  localparam int CNT_W_DEF = 27;

  localparam logic [7:0] SEG_TOP   = 8'b1001_1100;
  localparam logic [7:0] SEG_BOT   = 8'b1010_0011;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Returns {in3,in2,in1,in0}: top half walks digit 3->0, bottom half walks 0->3.
  function automatic logic [31:0] seg_pattern(input logic [2:0] p);
    logic [31:0] r;
    logic [1:0]  d;
    logic [7:0]  seg;
    r   = {4{SEG_BLANK}};
    d   = p[2] ? p[1:0] : 2'd3 - p[1:0];
    seg = p[2] ? SEG_BOT : SEG_TOP;
    case (d)
      2'd0:    r[7:0]   = seg;
      2'd1:    r[15:8]  = seg;
      2'd2:    r[23:16] = seg;
      default: r[31:24] = seg;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rot_square_ctrl_if.sv
// rtl/rot_square_ctrl_if.sv - control inputs and display outputs of rot_square_ctrl
interface rot_square_ctrl_if #(
  parameter int CNT_W = 27
);
  logic             en;
  logic             pause;
  logic             step;
  logic             dir;
  logic [CNT_W-1:0] period;
  logic [7:0]       in3;
  logic [7:0]       in2;
  logic [7:0]       in1;
  logic [7:0]       in0;
  logic [2:0]       pos;
  logic             step_tick;

  modport master (
    output en, pause, step, dir, period,
    input  in3, in2, in1, in0, pos, step_tick
  );

  modport slave (
    input  en, pause, step, dir, period,
    output in3, in2, in1, in0, pos, step_tick
  );
endinterface

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step-period prescaler; ticks once every period+1 cycles of run
module step_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  // >= rather than == so a period lowered below cnt fires at once instead of wrapping.
  always_comb tick = run && (cnt >= period);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/rot_square_ctrl.sv
// rtl/rot_square_ctrl.sv - sequencer animating one square around a 4-digit 7-segment display
module rot_square_ctrl
  import rot_sq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  rot_square_ctrl_if.slave  bus
);

  state_t      state;
  state_t      state_nxt;
  logic        run;
  logic        clear;
  logic        step_ok;
  logic        tick;
  logic        advance;
  logic [2:0]  pos;
  logic        step_tick;
  logic [31:0] pattern;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // en overrides everything, so it gates run/step here as well as the transitions.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    clear     = 1'b0;
    step_ok   = 1'b0;
    if (!bus.en) begin
      state_nxt = IDLE;
      clear     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = bus.pause ? PAUSE : RUN;
          clear     = 1'b1;
        end
        RUN: begin
          if (bus.pause) state_nxt = PAUSE;
          else           run       = 1'b1;
        end
        PAUSE: begin
          if (!bus.pause) state_nxt = RUN;
          step_ok = bus.step;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  step_timer #(.CNT_W(CNT_W)) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .clear  (clear),
    .period (bus.period),
    .tick   (tick)
  );

  always_comb advance = tick || step_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos       <= 3'd0;
      step_tick <= 1'b0;
      pattern   <= {4{SEG_BLANK}};
    end else begin
      step_tick <= advance;
      if (!bus.en)      pos <= 3'd0;
      else if (advance) pos <= bus.dir ? pos + 3'd1 : pos - 3'd1;
      // Blank on the same edge that enters IDLE; otherwise show the current position.
      if (state == IDLE || state_nxt == IDLE) pattern <= {4{SEG_BLANK}};
      else                                    pattern <= seg_pattern(pos);
    end
  end

  assign bus.pos       = pos;
  assign bus.step_tick = step_tick;
  assign bus.in3       = pattern[31:24];
  assign bus.in2       = pattern[23:16];
  assign bus.in1       = pattern[15:8];
  assign bus.in0       = pattern[7:0];

endmodule

// File: tb/tb_rot_square_ctrl.sv
// tb/tb_rot_square_ctrl.sv - directed self-checking bench for rot_square_ctrl
module tb_rot_square_ctrl;

  localparam logic [7:0] TOP = 8'b1001_1100;
  localparam logic [7:0] BOT = 8'b1010_0011;
  localparam logic [7:0] BLK = 8'hFF;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rot_square_ctrl_if #(.CNT_W(27)) bus ();

  rot_square_ctrl #(.CNT_W(27)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_disp(input int p);
    case (p)
      0:       return {TOP, BLK, BLK, BLK};
      1:       return {BLK, TOP, BLK, BLK};
      2:       return {BLK, BLK, TOP, BLK};
      3:       return {BLK, BLK, BLK, TOP};
      4:       return {BLK, BLK, BLK, BOT};
      5:       return {BLK, BLK, BOT, BLK};
      6:       return {BLK, BOT, BLK, BLK};
      default: return {BOT, BLK, BLK, BLK};
    endcase
  endfunction

  function automatic logic [31:0] disp();
    return {bus.in3, bus.in2, bus.in1, bus.in0};
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.step_tick && n < 2000);
    if (!bus.step_tick) check("tick_timeout", {31'd0, bus.step_tick}, 32'd1);
  endtask

  task automatic wait_pos(input int target);
    int k;
    k = 0;
    while (int'(bus.pos) != target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("pos_reach", {29'd0, bus.pos}, target);
  endtask

  initial begin
    int n;
    int tcount;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.en     = 1'b0;
    bus.pause  = 1'b0;
    bus.step   = 1'b0;
    bus.dir    = 1'b1;
    bus.period = 27'd3;
    repeat (2) @(negedge clk);
    check("rst_disp", disp(), 32'hFFFF_FFFF);
    check("rst_pos", {29'd0, bus.pos}, 0);
    check("rst_tick", {31'd0, bus.step_tick}, 0);

    // 1: clockwise, period 3 -> tick every 4 cycles
    reset  = 1'b0;
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_disp0", disp(), exp_disp(0));
    for (int i = 1; i <= 8; i++) begin
      wait_tick(n);
      check("t1_interval", n, 3);
      check("t1_pos", {29'd0, bus.pos}, i % 8);
      @(negedge clk);
      check("t1_disp", disp(), exp_disp(i % 8));
      check("t1_pulse", {31'd0, bus.step_tick}, 0);
    end

    // 2: counter-clockwise, period 0 -> step every cycle
    bus.dir    = 1'b0;
    bus.period = 27'd0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check("t2_pos", {29'd0, bus.pos}, 8 - j);
      check("t2_tick", {31'd0, bus.step_tick}, 1);
      if (j == 2) check("t2_disp7", disp(), exp_disp(7));
    end

    // 3: pause at pos 2 with cnt=4, single steps, resume from held cnt
    bus.dir    = 1'b1;
    bus.period = 27'd9;
    wait_pos(2);
    repeat (4) @(negedge clk);
    bus.pause = 1'b1;
    tcount = 0;
    repeat (100) begin
      @(negedge clk);
      tcount += int'(bus.step_tick);
    end
    check("t3_frozen_pos", {29'd0, bus.pos}, 2);
    check("t3_frozen_ticks", tcount, 0);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    check("t3_step1_pos", {29'd0, bus.pos}, 3);
    check("t3_step1_tick", {31'd0, bus.step_tick}, 1);
    @(negedge clk);
    check("t3_step_pulse", {31'd0, bus.step_tick}, 0);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    check("t3_step2_pos", {29'd0, bus.pos}, 4);
    check("t3_step2_tick", {31'd0, bus.step_tick}, 1);
    @(negedge clk);
    bus.pause = 1'b0;
    wait_tick(n);
    check("t3_resume_lat", n, 7);
    check("t3_resume_pos", {29'd0, bus.pos}, 5);

    // 4: shrink period below running cnt
    bus.period = 27'd1000;
    repeat (800) @(negedge clk);
    bus.period = 27'd10;
    wait_tick(n);
    check("t4_immediate", n, 1);
    check("t4_pos_a", {29'd0, bus.pos}, 6);
    wait_tick(n);
    check("t4_interval", n, 11);
    check("t4_pos_b", {29'd0, bus.pos}, 7);

    // 5: en drop with pause and step in the same cycle
    bus.period = 27'd0;
    wait_pos(5);
    bus.en    = 1'b0;
    bus.pause = 1'b1;
    bus.step  = 1'b1;
    @(negedge clk);
    check("t5_pos", {29'd0, bus.pos}, 0);
    check("t5_tick", {31'd0, bus.step_tick}, 0);
    check("t5_blank", disp(), 32'hFFFF_FFFF);
    bus.step   = 1'b0;
    bus.pause  = 1'b0;
    bus.period = 27'd50;
    bus.en     = 1'b1;
    @(negedge clk);
    check("t5_still_blank", disp(), 32'hFFFF_FFFF);
    @(negedge clk);
    check("t5_restart_disp", disp(), exp_disp(0));
    check("t5_restart_pos", {29'd0, bus.pos}, 0);

    // 6: asynchronous reset between edges
    bus.period = 27'd2;
    wait_pos(6);
    #2 reset = 1'b1;
    #1;
    check("t6_async_disp", disp(), 32'hFFFF_FFFF);
    check("t6_async_pos", {29'd0, bus.pos}, 0);
    check("t6_async_tick", {31'd0, bus.step_tick}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_restart_pos", {29'd0, bus.pos}, 0);
    check("t6_restart_disp", disp(), exp_disp(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
